// File: rtl/av_bfm_slave_mem.sv
// Avalon-MM slave memory model with burst support and pipelined read returns.
// Reads are queued with their word index, beat count and error flag, and
// returned in order after a fixed latency. Write bursts run through a small
// IDLE/WBURST state machine. An optional address window answers with SLAVEERROR.
module av_bfm_slave_mem #(
    parameter int unsigned    DW          = 32,
    parameter int unsigned    AW          = 32,
    parameter int unsigned    BURSTW      = 8,
    parameter int unsigned    MEM_WORDS   = 256,
    parameter int unsigned    RD_LATENCY  = 2,
    parameter int unsigned    WAIT_CYCLES = 0,
    parameter int unsigned    MAX_PENDING = 4,
    parameter logic [AW-1:0]  ERR_BASE    = '0,
    parameter logic [AW-1:0]  ERR_MASK    = '0
) (
    input  logic              av_clk_i,
    input  logic              av_rst_i,
    input  logic [AW-1:0]     av_address_i,
    input  logic [DW-1:0]     av_writedata_i,
    input  logic [DW/8-1:0]   av_byteenable_i,
    input  logic [BURSTW-1:0] av_burstcount_i,
    input  logic              av_write_i,
    input  logic              av_read_i,
    output logic              av_waitrequest_o,
    output logic              av_readdatavalid_o,
    output logic [1:0]        av_response_o,
    output logic [DW-1:0]     av_readdata_o,
    output logic              proto_err_o
);

    localparam int unsigned     BE_W      = DW / 8;
    localparam int unsigned     OFS       = $clog2(BE_W);
    localparam int unsigned     IW        = $clog2(MEM_WORDS);
    localparam int unsigned     PW        = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned     CW        = $clog2(MAX_PENDING + 1);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [CW-1:0]   PEND_MAX  = CW'(MAX_PENDING);
    localparam logic            ERR_EN    = (ERR_MASK != '0);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WBURST = 1'b1} wr_state_e;

    wr_state_e           state_r, state_s;
    logic [3:0]          wait_cnt_r, wait_cnt_s;
    logic [IW-1:0]       wr_idx_r, wr_idx_s;
    logic [BURSTW-1:0]   wr_left_r, wr_left_s;
    logic                wr_drop_r, wr_drop_s;
    logic                proto_err_r;

    logic [DW-1:0]       mem_r [MEM_WORDS];
    logic [IW-1:0]       fifo_idx_r [2**PW];
    logic [BURSTW-1:0]   fifo_cnt_r [2**PW];
    logic                fifo_err_r [2**PW];
    logic [PW-1:0]       wptr_r, rptr_r;
    logic [CW-1:0]       out_cnt_r, mature_cnt_r;
    logic                last_beat_r;
    logic [RD_LATENCY-1:0] lat_sr_r;

    logic [IW-1:0]       rd_idx_r;
    logic [BURSTW-1:0]   rd_left_r;
    logic                rd_err_r;
    logic                readdatavalid_r;
    logic [DW-1:0]       readdata_r;
    logic [1:0]          response_r;

    logic                wait_s, wr_acc_s, rd_acc_s, err_hit_s, full_s, proto_set_s;
    logic [IW-1:0]       cmd_idx_s, mem_idx_s, beat_idx_s;
    logic [BURSTW-1:0]   bc_s, beat_left_s;
    logic                mem_we_s, mature_now_s, head_ok_s, busy_s, issue_s, pop_s;
    logic                beat_err_s, last_s;
    logic [DW-1:0]       mem_word_s, beat_word_s;

    assign cmd_idx_s    = av_address_i[OFS +: IW];
    assign err_hit_s    = ERR_EN && ((av_address_i & ERR_MASK) == (ERR_BASE & ERR_MASK));
    assign bc_s         = (av_burstcount_i == '0) ? BURSTW'(1) : av_burstcount_i;
    assign full_s       = (out_cnt_r == PEND_MAX);
    assign wr_acc_s     = av_write_i & ~wait_s;
    assign rd_acc_s     = av_read_i & ~av_write_i & ~wait_s;
    assign mature_now_s = lat_sr_r[RD_LATENCY-1];
    assign head_ok_s    = (mature_cnt_r != '0) | mature_now_s;
    assign busy_s       = (rd_left_r != '0);
    assign issue_s      = busy_s | head_ok_s;
    assign pop_s        = ~busy_s & head_ok_s;
    assign beat_idx_s   = busy_s ? rd_idx_r : fifo_idx_r[rptr_r];
    assign beat_err_s   = busy_s ? rd_err_r : fifo_err_r[rptr_r];
    assign beat_left_s  = busy_s ? (rd_left_r - BURSTW'(1)) : (fifo_cnt_r[rptr_r] - BURSTW'(1));
    assign last_s       = issue_s & (beat_left_s == '0);
    assign mem_word_s   = mem_r[beat_idx_s];

    // Stall logic: reset, wait states on the first beat, reads blocked mid-write-burst or when the queue is full
    always_comb begin
        wait_s = 1'b0;
        if (!av_rst_i) begin
            wait_s = 1'b1;
        end else begin
            case (state_r)
                ST_WBURST: wait_s = av_read_i & ~av_write_i;
                ST_IDLE: begin
                    if (wait_cnt_r != 4'd0) begin
                        wait_s = 1'b1;
                    end else begin
                        wait_s = av_read_i & ~av_write_i & full_s;
                    end
                end
                default: wait_s = 1'b1;
            endcase
        end
    end

    // Write burst state machine and write-port addressing
    always_comb begin
        state_s   = state_r;
        wr_idx_s  = wr_idx_r;
        wr_left_s = wr_left_r;
        wr_drop_s = wr_drop_r;
        mem_we_s  = 1'b0;
        mem_idx_s = wr_idx_r;
        case (state_r)
            ST_IDLE: begin
                mem_idx_s = cmd_idx_s;
                if (wr_acc_s) begin
                    mem_we_s  = ~err_hit_s;
                    wr_idx_s  = cmd_idx_s + IW'(1);
                    wr_drop_s = err_hit_s;
                    wr_left_s = bc_s - BURSTW'(1);
                    state_s   = (bc_s > BURSTW'(1)) ? ST_WBURST : ST_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WBURST: begin
                if (wr_acc_s) begin
                    mem_we_s  = ~wr_drop_r;
                    wr_idx_s  = wr_idx_r + IW'(1);
                    wr_left_s = wr_left_r - BURSTW'(1);
                    state_s   = (wr_left_r == BURSTW'(1)) ? ST_IDLE : ST_WBURST;
                end else begin
                    state_s = ST_WBURST;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Wait counter: reload when idle or on acceptance, count down while a first-beat request is held
    always_comb begin
        wait_cnt_s = wait_cnt_r;
        if (state_r == ST_WBURST) begin
            wait_cnt_s = WAIT_INIT;
        end else if (!(av_read_i | av_write_i)) begin
            wait_cnt_s = WAIT_INIT;
        end else if (wr_acc_s | rd_acc_s) begin
            wait_cnt_s = WAIT_INIT;
        end else if (wait_cnt_r != 4'd0) begin
            wait_cnt_s = wait_cnt_r - 4'd1;
        end else begin
            wait_cnt_s = wait_cnt_r;
        end
    end

    // Protocol violations: read+write together in IDLE, or a read during a write burst
    always_comb begin
        proto_set_s = 1'b0;
        case (state_r)
            ST_IDLE:   proto_set_s = av_read_i & av_write_i;
            ST_WBURST: proto_set_s = av_read_i;
            default:   proto_set_s = 1'b0;
        endcase
    end

    // Read data with same-edge write forwarding so a write at the issue edge is visible
    always_comb begin
        beat_word_s = mem_word_s;
        for (int i = 0; i < BE_W; i++) begin
            beat_word_s[8*i +: 8] = (mem_we_s && (mem_idx_s == beat_idx_s) && av_byteenable_i[i])
                                    ? av_writedata_i[8*i +: 8] : mem_word_s[8*i +: 8];
        end
    end

    // Memory array: byte-lane writes, contents survive reset
    always_ff @(posedge av_clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (av_byteenable_i[i]) begin
                    mem_r[mem_idx_s][8*i +: 8] <= av_writedata_i[8*i +: 8];
                end
            end
        end
    end

    // Pending-read queue storage, written on each accepted read command
    always_ff @(posedge av_clk_i) begin
        if (rd_acc_s) begin
            fifo_idx_r[wptr_r] <= cmd_idx_s;
            fifo_cnt_r[wptr_r] <= bc_s;
            fifo_err_r[wptr_r] <= err_hit_s;
        end
    end

    // Control state, queue bookkeeping and registered read-return outputs
    always_ff @(posedge av_clk_i or negedge av_rst_i) begin
        if (!av_rst_i) begin
            state_r         <= ST_IDLE;
            wait_cnt_r      <= WAIT_INIT;
            wr_idx_r        <= '0;
            wr_left_r       <= '0;
            wr_drop_r       <= 1'b0;
            proto_err_r     <= 1'b0;
            wptr_r          <= '0;
            rptr_r          <= '0;
            out_cnt_r       <= '0;
            mature_cnt_r    <= '0;
            last_beat_r     <= 1'b0;
            lat_sr_r        <= '0;
            rd_idx_r        <= '0;
            rd_left_r       <= '0;
            rd_err_r        <= 1'b0;
            readdatavalid_r <= 1'b0;
            readdata_r      <= '0;
            response_r      <= 2'b00;
        end else begin
            state_r      <= state_s;
            wait_cnt_r   <= wait_cnt_s;
            wr_idx_r     <= wr_idx_s;
            wr_left_r    <= wr_left_s;
            wr_drop_r    <= wr_drop_s;
            proto_err_r  <= proto_err_r | proto_set_s;
            wptr_r       <= wptr_r + PW'(rd_acc_s);
            rptr_r       <= rptr_r + PW'(pop_s);
            out_cnt_r    <= out_cnt_r + CW'(rd_acc_s) - CW'(last_beat_r);
            mature_cnt_r <= mature_cnt_r + CW'(mature_now_s) - CW'(pop_s);
            last_beat_r  <= last_s;
            lat_sr_r     <= (lat_sr_r << 1) | RD_LATENCY'(rd_acc_s);
            if (issue_s) begin
                rd_idx_r        <= beat_idx_s + IW'(1);
                rd_left_r       <= beat_left_s;
                rd_err_r        <= beat_err_s;
                readdatavalid_r <= 1'b1;
                readdata_r      <= beat_err_s ? '0 : beat_word_s;
                response_r      <= beat_err_s ? 2'b10 : 2'b00;
            end else begin
                readdatavalid_r <= 1'b0;
                readdata_r      <= '0;
                response_r      <= 2'b00;
            end
        end
    end

    assign av_waitrequest_o   = wait_s;
    assign av_readdatavalid_o = readdatavalid_r;
    assign av_readdata_o      = readdata_r;
    assign av_response_o      = response_r;
    assign proto_err_o        = proto_err_r;

endmodule

// File: tb/tb_av_bfm_slave_mem.sv
// Directed bench for av_bfm_slave_mem: one instance with an error window,
// one with wait states. A negedge monitor records every read beat with its cycle.
module tb_av_bfm_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  bc;
    logic        wr_a, rd_a, wr_b, rd_b, sel_b;
    logic        wait_a, rdv_a, perr_a, wait_b, rdv_b, perr_b;
    logic [1:0]  resp_a, resp_b;
    logic [31:0] rdata_a, rdata_b;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] q_data[$];
    logic [1:0]  q_resp[$];
    int          q_cyc[$];

    av_bfm_slave_mem #(.ERR_BASE(32'h0000_0100), .ERR_MASK(32'h0000_0F00)) u_dut (
        .av_clk_i(clk), .av_rst_i(rst_n), .av_address_i(address), .av_writedata_i(wdata),
        .av_byteenable_i(be), .av_burstcount_i(bc), .av_write_i(wr_a), .av_read_i(rd_a),
        .av_waitrequest_o(wait_a), .av_readdatavalid_o(rdv_a), .av_response_o(resp_a),
        .av_readdata_o(rdata_a), .proto_err_o(perr_a));

    av_bfm_slave_mem #(.WAIT_CYCLES(3)) u_dut_w (
        .av_clk_i(clk), .av_rst_i(rst_n), .av_address_i(address), .av_writedata_i(wdata),
        .av_byteenable_i(be), .av_burstcount_i(bc), .av_write_i(wr_b), .av_read_i(rd_b),
        .av_waitrequest_o(wait_b), .av_readdatavalid_o(rdv_b), .av_response_o(resp_b),
        .av_readdata_o(rdata_b), .proto_err_o(perr_b));

    always #5 clk = ~clk;

    // Edge counter used to timestamp acceptance and returned beats
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record beats from the selected instance; idle beats must carry zero data and OKAY
    always @(negedge clk) begin
        if (sel_b ? rdv_b : rdv_a) begin
            q_data.push_back(sel_b ? rdata_b : rdata_a);
            q_resp.push_back(sel_b ? resp_b : resp_a);
            q_cyc.push_back(cyc);
        end
        if (!rdv_a) check_eq("idle_zero_a", 64'({rdata_a, resp_a}), 64'd0);
        if (!rdv_b) check_eq("idle_zero_b", 64'({rdata_b, resp_b}), 64'd0);
    end

    task automatic clear_q();
        q_data.delete();
        q_resp.delete();
        q_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command and hold it until accepted; returns acceptance edge and stall count
    task automatic issue(input logic use_b, input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] e, input logic [7:0] nb,
                         output int acc, output int waits);
        sel_b = use_b; address = a; wdata = d; be = e; bc = nb;
        wr_a = w & ~use_b; rd_a = r & ~use_b;
        wr_b = w & use_b;  rd_b = r & use_b;
        waits = 0;
        #1;
        while ((use_b ? wait_b : wait_a) && (waits < 40)) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (waits >= 40) check_eq("accept_timeout", 64'(use_b ? wait_b : wait_a), 64'd0);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, summary not printed", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, ra, w;
        int waits[5];
        int acc0;
        rst_n = 1'b0; address = 32'd0; wdata = 32'd0; be = 4'h0; bc = 8'd0;
        wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0; sel_b = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wait_a", 64'(wait_a), 64'd1);
        check_eq("rst_wait_b", 64'(wait_b), 64'd1);
        check_eq("rst_rdv", 64'(rdv_a), 64'd0);
        check_eq("rst_rdata", 64'(rdata_a), 64'd0);
        check_eq("rst_resp", 64'(resp_a), 64'd0);
        check_eq("rst_perr", 64'(perr_a), 64'd0);
        #3 rst_n = 1'b1;
        #1;
        check_eq("post_rst_wait_a", 64'(wait_a), 64'd0);
        check_eq("post_rst_wait_b", 64'(wait_b), 64'd1);
        @(posedge clk);
        #1;

        // Single write then single read with fixed latency
        issue(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 8'd1, acc, w);
        idle(1);
        clear_q();
        issue(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 8'd1, ra, w);
        idle(5);
        check_eq("t1_beats", 64'(q_data.size()), 64'd1);
        check_eq("t1_latency", 64'(q_cyc[0] - ra), 64'd2);
        check_eq("t1_data", 64'(q_data[0]), 64'hDEADBEEF);
        check_eq("t1_resp", 64'(q_resp[0]), 64'd0);

        // Write burst of 4 with no wait states on beats 2..4, then read burst back
        issue(1'b0, 1'b1, 1'b0, 32'h0, 32'd1, 4'hF, 8'd4, acc, w);
        for (int k = 2; k <= 4; k++) begin
            issue(1'b0, 1'b1, 1'b0, 32'h80, 32'(k), 4'hF, 8'd9, acc, w);
            check_eq("t2_wburst_wait", 64'(w), 64'd0);
        end
        clear_q();
        issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 8'd4, ra, w);
        idle(8);
        check_eq("t2_beats", 64'(q_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) check_eq("t2_data", 64'(q_data[i]), 64'(i + 1));
        check_eq("t2_first_cyc", 64'(q_cyc[0] - ra), 64'd2);
        check_eq("t2_last_cyc", 64'(q_cyc[3] - ra), 64'd5);

        // Fill words 0..9, then five back-to-back 2-beat read bursts against a 4-deep queue
        issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 4'hF, 8'd10, acc, w);
        for (int k = 1; k < 10; k++) issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h100 + 32'(k), 4'hF, 8'd0, acc, w);
        clear_q();
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 1'b0, 1'b1, 32'(8 * i), 32'h0, 4'hF, 8'd2, acc, waits[i]);
            if (i == 0) acc0 = acc;
        end
        idle(12);
        check_eq("t3_no_stall_1to4", 64'(waits[0] + waits[1] + waits[2] + waits[3]), 64'd0);
        check_eq("t3_stall_5th", 64'(waits[4] > 0), 64'd1);
        check_eq("t3_beats", 64'(q_data.size()), 64'd10);
        for (int i = 0; i < 10; i++) check_eq("t3_data", 64'(q_data[i]), 64'(32'h100 + 32'(i)));
        check_eq("t3_first_cyc", 64'(q_cyc[0] - acc0), 64'd2);
        check_eq("t3_no_gaps", 64'(q_cyc[9] - q_cyc[0]), 64'd9);

        // Error window: discarded write, SLAVEERROR reads, normal read outside window
        issue(1'b0, 1'b1, 1'b0, 32'h504, 32'h12345678, 4'hF, 8'd1, acc, w);
        issue(1'b0, 1'b1, 1'b0, 32'h104, 32'h55, 4'hF, 8'd1, acc, w);
        clear_q();
        issue(1'b0, 1'b0, 1'b1, 32'h104, 32'h0, 4'hF, 8'd2, acc, w);
        issue(1'b0, 1'b0, 1'b1, 32'h504, 32'h0, 4'hF, 8'd1, acc, w);
        issue(1'b0, 1'b0, 1'b1, 32'h004, 32'h0, 4'hF, 8'd1, acc, w);
        idle(8);
        check_eq("t4_beats", 64'(q_data.size()), 64'd4);
        check_eq("t4_err_resp0", 64'(q_resp[0]), 64'h2);
        check_eq("t4_err_data0", 64'(q_data[0]), 64'd0);
        check_eq("t4_err_resp1", 64'(q_resp[1]), 64'h2);
        check_eq("t4_err_data1", 64'(q_data[1]), 64'd0);
        check_eq("t4_discarded", 64'(q_data[2]), 64'h12345678);
        check_eq("t4_ok_resp", 64'(q_resp[3]), 64'd0);
        check_eq("t4_ok_data", 64'(q_data[3]), 64'h101);

        // Wait states and partial byteenable on the WAIT_CYCLES=3 instance
        issue(1'b1, 1'b1, 1'b0, 32'h20, 32'h11111111, 4'hF, 8'd1, acc, w);
        check_eq("t5_wr_waits", 64'(w), 64'd3);
        issue(1'b1, 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'h3, 8'd1, acc, w);
        idle(1);
        clear_q();
        issue(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 8'd1, ra, w);
        check_eq("t5_rd_waits", 64'(w), 64'd3);
        idle(6);
        check_eq("t5_beats", 64'(q_data.size()), 64'd1);
        check_eq("t5_data", 64'(q_data[0]), 64'h1111CCDD);
        check_eq("t5_latency", 64'(q_cyc[0] - ra), 64'd2);
        sel_b = 1'b0;

        // Read+write together: write wins, read dropped, sticky flag
        clear_q();
        issue(1'b0, 1'b1, 1'b1, 32'h30, 32'h77, 4'hF, 8'd1, acc, w);
        check_eq("t6_perr_set", 64'(perr_a), 64'd1);
        idle(5);
        check_eq("t6_read_ignored", 64'(q_data.size()), 64'd0);
        issue(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 4'hF, 8'd1, acc, w);
        idle(5);
        check_eq("t6_write_won", 64'(q_data[0]), 64'h77);
        check_eq("t6_perr_sticky", 64'(perr_a), 64'd1);

        // Reset in the middle of a 4-beat read return
        clear_q();
        issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 8'd4, ra, w);
        idle(2);
        check_eq("t6_rdv_before_rst", 64'(rdv_a), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rdv_in_rst", 64'(rdv_a), 64'd0);
        check_eq("t6_perr_cleared", 64'(perr_a), 64'd0);
        check_eq("t6_wait_in_rst", 64'(wait_a), 64'd1);
        idle(2);
        rst_n = 1'b1;
        idle(8);
        check_eq("t6_no_beats_after_rst", 64'(q_data.size()), 64'd0);
        check_eq("t6_rdv_stays_low", 64'(rdv_a), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/av_bfm_slave_mem.md
Name: av_bfm_slave_mem

Overview:
Synthesizable, parametrised Avalon-MM slave memory model. It is the pipelined successor to the task-driven slave BFM.
- Backs an internal word array.
- Supports burst reads and writes, configurable fixed read latency, configurable wait states, multiple outstanding read bursts and an error-address window.
- Sits on the DUT's master port in benches and FPGA loopback tests, with no testbench tasks required.

Parameters:
DW, 32, data width in bits (multiple of 8)
AW, 32, byte address width
BURSTW, 8, burstcount width
MEM_WORDS, 256, memory depth in words (power of 2)
RD_LATENCY, 2, cycles from read acceptance to first readdatavalid (1..8)
WAIT_CYCLES, 0, waitrequest-high cycles inserted before each command is accepted (0..15)
MAX_PENDING, 4, outstanding read bursts queued (power of 2, >=1)
ERR_BASE, 0, byte base of error window
ERR_MASK, 0, address bits compared for error window (0 = window disabled)

Ports:
av_clk_i  in  1  clock
av_rst_i  in  1  asynchronous reset, active-low
av_address_i  in  AW  byte address
av_writedata_i  in  DW  write data
av_byteenable_i  in  DW/8  byte lanes
av_burstcount_i  in  BURSTW  beats in burst
av_write_i  in  1  write request
av_read_i  in  1  read request
av_waitrequest_o  out  1  stall
av_readdatavalid_o  out  1  read beat valid
av_response_o  out  2  00 OKAY, 10 SLAVEERROR
av_readdata_o  out  DW  read data
proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
Reset and acceptance:
- Reset (av_rst_i=0, async) forces the following. Memory contents are not cleared.
  - waitrequest=1
  - readdatavalid=0
  - readdata=0
  - response=00
  - proto_err=0
  - pending FIFO empty
  - burst state IDLE
  - wait counter=WAIT_CYCLES
- First cycle after reset release: waitrequest follows normal rules.
- Transfer accepted on a clock edge where (read|write)=1 and waitrequest=0.
- Word index = (address / (DW/8) + beat) mod MEM_WORDS, so addresses wrap silently.
- burstcount 0 is treated as 1.

Wait states:
- Wait counter loads WAIT_CYCLES when idle.
- The counter decrements each cycle a request is held.
- waitrequest stays high until the counter reaches 0.
- Wait states apply to the first beat only. Write beats 2..N are accepted with no wait states.

State machine (IDLE, WBURST):
- IDLE + accepted write, burstcount>1: write beat 0, load remaining=burstcount-1, go to WBURST.
- IDLE + accepted write, burstcount<=1: write beat 0, stay in IDLE.
- WBURST + accepted write: write the next word. Address and burstcount are ignored. Decrement remaining; on 0, return to IDLE.
- WBURST + read asserted: set proto_err, hold waitrequest=1 until write is seen.
- Writes honour byteenable per lane.
- Writes whose first address falls in the error window (addr & ERR_MASK == ERR_BASE & ERR_MASK, mask nonzero) are discarded for the whole burst.

Reads:
- IDLE + accepted read: push {word index, count, err flag} into the pending FIFO.
- waitrequest=1 for reads while the FIFO is full. A read and a FIFO pop in the same cycle is allowed.
- Return engine: the first beat of the head entry asserts readdatavalid exactly RD_LATENCY cycles after the acceptance edge, provided the engine is idle. Otherwise it starts the cycle after the previous burst's last beat.
- Beats of one burst are back-to-back, one per cycle, incrementing word index.
- Read data is the memory content at beat issue time. A write accepted at or before the issue edge is visible (write-before-read).
- Error-window reads return readdata=0 and response=10 on every beat. Otherwise response=00.
- readdatavalid=0 implies readdata=0 and response=00.

Protocol violations:
- read and write both high in IDLE: the write wins, the read is ignored, proto_err set.
- proto_err clears only on reset.

Reset mid-burst: all pending reads are dropped and no further readdatavalid is issued. A partial write burst is abandoned; beats already written persist.

Test Plan:
- Defaults. Single write 0xDEADBEEF to 0x10 with byteenable 0xF, then read 0x10 -> readdatavalid exactly 2 cycles after acceptance, readdata 0xDEADBEEF, response 00.
- Write burst of 4 at 0x0 with data 1,2,3,4, then read burst of 4 at 0x0 -> four consecutive beats 1,2,3,4; waitrequest never high during the write beats.
- MAX_PENDING=4, read bursts of 2 issued every cycle -> waitrequest rises on the 5th command; all 10 beats return in order with no gaps.
- ERR_BASE=0x100, ERR_MASK=0xF00. Write 0x55 to 0x104, read 0x104 burst 2 -> both beats response 10, readdata 0; then read 0x004 -> response 00.
- WAIT_CYCLES=3. Read asserted at cycle t -> accepted at t+3; byteenable 0x3 write of 0xAABBCCDD over 0x11111111 -> reads 0x1111CCDD.
- Read and write asserted together -> proto_err=1 next cycle; assert av_rst_i=0 during a 4-beat read return -> readdatavalid=0 immediately and stays 0; proto_err=0.
